// File: rtl/flags_unit.sv
// NZCV flags register with exception save stack; updates are visible one edge after the request.
// No backpressure: every request is resolved in the cycle it arrives, by fixed priority.
module flags_unit #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000,
  parameter int         STACK_DEPTH = 4,
  parameter int         PTR_W       = 3
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             StallE,
  input  logic [1:0]       FlagWriteE,
  input  logic             CondEx,
  input  logic [3:0]       ALUFlags,
  input  logic             MsrWrEn,
  input  logic [3:0]       MsrData,
  input  logic             ExcEntry,
  input  logic             ExcReturn,
  output logic [3:0]       Flags,
  output logic [PTR_W-1:0] StackCount,
  output logic             StackOvf,
  output logic             StackUnf
);

  localparam int               IDX_W     = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [PTR_W-1:0] DEPTH_CNT = PTR_W'(STACK_DEPTH);

  logic [3:0]       stack_q [STACK_DEPTH];
  logic [3:0]       flags_d;
  logic [PTR_W-1:0] count_d;
  logic             ovf_d;
  logic             unf_d;
  logic             push;
  logic [IDX_W-1:0] top_idx;
  logic [IDX_W-1:0] push_idx;

  assign top_idx  = IDX_W'(StackCount - 1'b1);
  assign push_idx = IDX_W'(StackCount);

  // Exceptions flush the Execute instruction, so they pre-empt MSR/ALU writes.
  always_comb begin
    flags_d = Flags;
    count_d = StackCount;
    ovf_d   = StackOvf;
    unf_d   = StackUnf;
    push    = 1'b0;
    if (ExcReturn) begin
      if (StackCount != '0) begin
        flags_d = stack_q[top_idx];
        count_d = StackCount - 1'b1;
      end else begin
        unf_d = 1'b1;
      end
    end else if (ExcEntry) begin
      if (StackCount < DEPTH_CNT) begin
        push    = 1'b1;
        count_d = StackCount + 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (!StallE) begin
      if (MsrWrEn) begin
        flags_d = MsrData;
      end else if (CondEx) begin
        if (FlagWriteE[1]) flags_d[3:2] = ALUFlags[3:2];
        if (FlagWriteE[0]) flags_d[1:0] = ALUFlags[1:0];
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      Flags      <= RESET_FLAGS;
      StackCount <= '0;
      StackOvf   <= 1'b0;
      StackUnf   <= 1'b0;
    end else begin
      Flags      <= flags_d;
      StackCount <= count_d;
      StackOvf   <= ovf_d;
      StackUnf   <= unf_d;
    end
  end

  // Stack contents need no reset; only StackCount qualifies them.
  always_ff @(posedge CLK) begin
    if (push) stack_q[push_idx] <= Flags;
  end

endmodule

// File: tb/tb_flags_unit.sv
// Directed bench for flags_unit: hand-computed vectors for masking, MSR, stack and sticky errors.
module tb_flags_unit;

  logic       CLK = 1'b0;
  logic       nRST = 1'b1;
  logic       StallE = 1'b0;
  logic [1:0] FlagWriteE = 2'b00;
  logic       CondEx = 1'b0;
  logic [3:0] ALUFlags = 4'b0000;
  logic       MsrWrEn = 1'b0;
  logic [3:0] MsrData = 4'b0000;
  logic       ExcEntry = 1'b0;
  logic       ExcReturn = 1'b0;
  logic [3:0] Flags;
  logic [2:0] StackCount;
  logic       StackOvf;
  logic       StackUnf;

  int checks = 0;
  int failures = 0;

  flags_unit #(.RESET_FLAGS(4'b0000), .STACK_DEPTH(4), .PTR_W(3)) dut (
    .CLK(CLK), .nRST(nRST), .StallE(StallE), .FlagWriteE(FlagWriteE),
    .CondEx(CondEx), .ALUFlags(ALUFlags), .MsrWrEn(MsrWrEn), .MsrData(MsrData),
    .ExcEntry(ExcEntry), .ExcReturn(ExcReturn), .Flags(Flags),
    .StackCount(StackCount), .StackOvf(StackOvf), .StackUnf(StackUnf)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    StallE = 0; FlagWriteE = 2'b00; CondEx = 0; ALUFlags = 4'b0000;
    MsrWrEn = 0; MsrData = 4'b0000; ExcEntry = 0; ExcReturn = 0;
  endtask

  task automatic msr(input logic [3:0] v);
    idle_inputs();
    MsrWrEn = 1; MsrData = v;
    step();
    idle_inputs();
  endtask

  task automatic check_all(input string tag, input logic [3:0] f, input logic [2:0] c,
                           input logic o, input logic u);
    check({tag, ".flags"}, {4'b0, Flags}, {4'b0, f});
    check({tag, ".count"}, {5'b0, StackCount}, {5'b0, c});
    check({tag, ".ovf"}, {7'b0, StackOvf}, {7'b0, o});
    check({tag, ".unf"}, {7'b0, StackUnf}, {7'b0, u});
  endtask

  initial begin
    // Asynchronous reset before any clock edge
    #2 nRST = 0;
    #1 check_all("reset_async", 4'b0000, 3'd0, 1'b0, 1'b0);
    step();
    #2 nRST = 1;
    for (int i = 0; i < 5; i++) step();
    check_all("idle", 4'b0000, 3'd0, 1'b0, 1'b0);

    // Masked ALU writes
    ALUFlags = 4'b1111; FlagWriteE = 2'b10; CondEx = 1;
    step(); check("alu_nz", {4'b0, Flags}, 8'b0000_1100);
    ALUFlags = 4'b0011; FlagWriteE = 2'b01;
    step(); check("alu_cv", {4'b0, Flags}, 8'b0000_1111);
    CondEx = 0; FlagWriteE = 2'b11; ALUFlags = 4'b0000;
    step(); check("alu_condfail", {4'b0, Flags}, 8'b0000_1111);
    idle_inputs();

    // Stall blocks MSR and ALU; MSR beats ALU
    StallE = 1; MsrWrEn = 1; MsrData = 4'b0101;
    step(); check("msr_stalled", {4'b0, Flags}, 8'b0000_1111);
    StallE = 0;
    step(); check("msr_write", {4'b0, Flags}, 8'b0000_0101);
    MsrData = 4'b1010; FlagWriteE = 2'b11; CondEx = 1; ALUFlags = 4'b0000;
    step(); check("msr_over_alu", {4'b0, Flags}, 8'b0000_1010);
    idle_inputs();
    StallE = 1; CondEx = 1; FlagWriteE = 2'b11; ALUFlags = 4'b0101;
    step(); check("alu_stalled", {4'b0, Flags}, 8'b0000_1010);
    idle_inputs();

    // Nested exceptions
    msr(4'b0001);
    ExcEntry = 1;
    step(); check_all("nest_push1", 4'b0001, 3'd1, 1'b0, 1'b0);
    ExcEntry = 0;
    msr(4'b0010);
    ExcEntry = 1;
    step(); check_all("nest_push2", 4'b0010, 3'd2, 1'b0, 1'b0);
    ExcEntry = 0; ExcReturn = 1;
    step(); check_all("nest_pop1", 4'b0010, 3'd1, 1'b0, 1'b0);
    step(); check_all("nest_pop2", 4'b0001, 3'd0, 1'b0, 1'b0);
    idle_inputs();

    // Exception entry flushes a same-cycle ALU write; entry+return acts as return only
    msr(4'b0100);
    ExcEntry = 1; CondEx = 1; FlagWriteE = 2'b11; ALUFlags = 4'b1111;
    step(); check_all("flush_push", 4'b0100, 3'd1, 1'b0, 1'b0);
    idle_inputs();
    msr(4'b0000);
    check("flush_msr", {4'b0, Flags}, 8'b0000_0000);
    ExcEntry = 1; ExcReturn = 1; MsrWrEn = 1; MsrData = 4'b1001;
    step(); check_all("entry_and_return", 4'b0100, 3'd0, 1'b0, 1'b0);
    idle_inputs();

    // Fill past depth; stalls must not block exceptions
    for (int i = 0; i < 5; i++) begin
      msr(4'(i + 1));
      ExcEntry = 1; StallE = (i == 2);
      step();
      check($sformatf("fill%0d.count", i), {5'b0, StackCount}, 8'((i < 4) ? i + 1 : 4));
      idle_inputs();
    end
    check_all("full", 4'b0101, 3'd4, 1'b1, 1'b0);

    // Drain past empty: pops return 4,3,2,1 then hold
    msr(4'b1111);
    for (int i = 0; i < 5; i++) begin
      ExcReturn = 1;
      step();
      check($sformatf("drain%0d.flags", i), {4'b0, Flags}, 8'((i < 4) ? 4 - i : 1));
    end
    idle_inputs();
    check_all("empty", 4'b0001, 3'd0, 1'b1, 1'b1);

    // Sticky bits survive ordinary activity
    msr(4'b0110);
    for (int i = 0; i < 3; i++) step();
    check_all("sticky", 4'b0110, 3'd0, 1'b1, 1'b1);

    // Reset mid-sequence, then a fresh start
    ExcEntry = 1;
    step();
    #2 nRST = 0;
    #1 check_all("reset_mid", 4'b0000, 3'd0, 1'b0, 1'b0);
    idle_inputs();
    step();
    #2 nRST = 1;
    ExcReturn = 1;
    step(); check_all("post_reset_pop", 4'b0000, 3'd0, 1'b0, 1'b1);
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
